// File: rtl/mt_pkg.sv
// Shared definitions for the MT command sequencer: function codes, FSM state
// type, timeout default and function-code classification helpers.
package mt_pkg;

  localparam logic [23:0] OPI_TIMEOUT_DEF = 24'd5_000_000;

  localparam logic [4:0] FN_NOP    = 5'o00;
  localparam logic [4:0] FN_UNLOAD = 5'o01;
  localparam logic [4:0] FN_REWIND = 5'o03;
  localparam logic [4:0] FN_DRVCLR = 5'o04;
  localparam logic [4:0] FN_PRESET = 5'o10;
  localparam logic [4:0] FN_ERASE  = 5'o12;
  localparam logic [4:0] FN_WRTM   = 5'o13;
  localparam logic [4:0] FN_SPCFWD = 5'o14;
  localparam logic [4:0] FN_SPCREV = 5'o15;
  localparam logic [4:0] FN_WCHKF  = 5'o24;
  localparam logic [4:0] FN_WCHKR  = 5'o27;
  localparam logic [4:0] FN_WRF    = 5'o30;
  localparam logic [4:0] FN_RDF    = 5'o34;
  localparam logic [4:0] FN_RDR    = 5'o37;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_MOTION = 3'd2,
    ST_XFER   = 3'd3,
    ST_DONE   = 3'd4
  } mtState_t;

  function automatic logic fnMotion(input logic [4:0] fn);
    case (fn)
      FN_UNLOAD, FN_REWIND, FN_ERASE, FN_WRTM, FN_SPCFWD, FN_SPCREV: fnMotion = 1'b1;
      default: fnMotion = 1'b0;
    endcase
  endfunction

  function automatic logic fnXfer(input logic [4:0] fn);
    case (fn)
      FN_WCHKF, FN_WCHKR, FN_WRF, FN_RDF, FN_RDR: fnXfer = 1'b1;
      default: fnXfer = 1'b0;
    endcase
  endfunction

  function automatic logic fnLegal(input logic [4:0] fn);
    case (fn)
      FN_NOP, FN_DRVCLR, FN_PRESET: fnLegal = 1'b1;
      default: fnLegal = fnMotion(fn) | fnXfer(fn);
    endcase
  endfunction

  // Functions that write the tape and therefore honour the write lock.
  function automatic logic fnWrite(input logic [4:0] fn);
    case (fn)
      FN_ERASE, FN_WRTM, FN_WRF: fnWrite = 1'b1;
      default: fnWrite = 1'b0;
    endcase
  endfunction

  // Functions that move the tape backwards and cannot start at BOT.
  function automatic logic fnReverse(input logic [4:0] fn);
    case (fn)
      FN_SPCREV, FN_WCHKR, FN_RDR: fnReverse = 1'b1;
      default: fnReverse = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mt_opi_timer.sv
// Operation-incomplete watchdog: counts cycles while a motion or transfer is
// running and flags the last allowed cycle.
module mt_opi_timer
  import mt_pkg::*;
#(
  parameter logic [23:0] OPI_TIMEOUT = OPI_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  logic [23:0] countR;

  // Cycle counter, restarted as the sequencer enters a running state.
  always_ff @(posedge clk) begin
    if (rst) begin
      countR <= 24'd0;
    end else if (clear) begin
      countR <= 24'd0;
    end else if (run) begin
      countR <= countR + 24'd1;
    end else begin
      countR <= countR;
    end
  end

  assign expire = run && (countR == (OPI_TIMEOUT - 24'd1));

endmodule

// File: rtl/mt_cmd_seq.sv
// MT command sequencer: decodes CS1 GO functions, launches motions/transfers
// and raises error and attention flags. Define MT_OPI_TIMEOUT_EN for the OPI watchdog.
module mt_cmd_seq
  import mt_pkg::*;
#(
  parameter logic [23:0] OPI_TIMEOUT = OPI_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mtINIT,
  input  logic       mtGO,
  input  logic [4:0] mtFUN,
  input  logic       mtWRL,
  input  logic       mtBOT,
  input  logic       mtERR,
  input  logic       mtMOTDONE,
  input  logic       mtXFRDONE,
  input  logic       mtCLRATA,
  output logic       mtMOTSTB,
  output logic       mtXFRSTB,
  output logic       mtDRVCLR,
  output logic       mtSETILF,
  output logic       mtSETNEF,
  output logic       mtSETRMR,
  output logic       mtSETOPI,
  output logic       mtDRY,
  output logic       mtATA
);

  mtState_t   state;
  logic [4:0] funR;
  logic       motFnR;
  logic       opiExpire;
  logic       ilfHit, nefHit, opiHit, errHit;
  logic       ataSet, ataClr;

`ifdef MT_OPI_TIMEOUT_EN
  mt_opi_timer #(.OPI_TIMEOUT(OPI_TIMEOUT)) uTimer (
    .clk    (clk),
    .rst    (rst || mtINIT),
    .clear  (state == ST_DECODE),
    .run    ((state == ST_MOTION) || (state == ST_XFER)),
    .expire (opiExpire)
  );
`else
  // Without the watchdog the limit has no effect and a running function waits forever.
  assign opiExpire = 1'b0 & (OPI_TIMEOUT == 24'd0);
`endif

  // Error and attention conditions for the current cycle.
  always_comb begin
    ilfHit = 1'b0;
    nefHit = 1'b0;
    opiHit = 1'b0;
    if (state == ST_DECODE) begin
      ilfHit = !fnLegal(funR);
      nefHit = fnLegal(funR) && ((mtWRL && fnWrite(funR)) || (mtBOT && fnReverse(funR)));
    end else begin
      opiHit = opiExpire && (((state == ST_MOTION) && !mtMOTDONE) ||
                             ((state == ST_XFER) && !mtXFRDONE));
    end
    errHit = ilfHit || nefHit || opiHit;
    ataSet = errHit || ((state == ST_DONE) && (motFnR || mtERR));
    ataClr = mtCLRATA || ((state == ST_DECODE) && (funR == FN_DRVCLR));
  end

  // Sequencer FSM with registered strobes, error pulses, ready and attention.
  always_ff @(posedge clk) begin
    if (rst || mtINIT) begin
      state    <= ST_IDLE;
      funR     <= FN_NOP;
      motFnR   <= 1'b0;
      mtMOTSTB <= 1'b0;
      mtXFRSTB <= 1'b0;
      mtDRVCLR <= 1'b0;
      mtSETILF <= 1'b0;
      mtSETNEF <= 1'b0;
      mtSETRMR <= 1'b0;
      mtSETOPI <= 1'b0;
      mtDRY    <= 1'b1;
      mtATA    <= 1'b0;
    end else begin
      mtMOTSTB <= 1'b0;
      mtXFRSTB <= 1'b0;
      mtDRVCLR <= 1'b0;
      mtSETILF <= ilfHit;
      mtSETNEF <= nefHit;
      mtSETOPI <= opiHit;
      // A decode or timeout error takes the single error-pulse slot over RMR.
      mtSETRMR <= mtGO && (state != ST_IDLE) && !errHit;
      mtATA    <= ataSet ? 1'b1 : (ataClr ? 1'b0 : mtATA);
      case (state)
        ST_IDLE: begin
          if (mtGO) begin
            funR   <= mtFUN;
            motFnR <= fnMotion(mtFUN);
            state  <= ST_DECODE;
            mtDRY  <= 1'b0;
          end else begin
            mtDRY <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (errHit) begin
            state <= ST_IDLE;
            mtDRY <= 1'b1;
          end else if (fnMotion(funR)) begin
            mtMOTSTB <= 1'b1;
            state    <= ST_MOTION;
          end else if (fnXfer(funR)) begin
            mtXFRSTB <= 1'b1;
            state    <= ST_XFER;
          end else begin
            mtDRVCLR <= (funR == FN_DRVCLR);
            state    <= ST_IDLE;
            mtDRY    <= 1'b1;
          end
        end
        ST_MOTION: begin
          if (mtMOTDONE) begin
            state <= ST_DONE;
          end else if (opiHit) begin
            state <= ST_IDLE;
            mtDRY <= 1'b1;
          end else begin
            state <= ST_MOTION;
          end
        end
        ST_XFER: begin
          if (mtXFRDONE) begin
            state <= ST_DONE;
          end else if (opiHit) begin
            state <= ST_IDLE;
            mtDRY <= 1'b1;
          end else begin
            state <= ST_XFER;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          mtDRY <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          mtDRY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mt_cmd_seq.sv
// Self-checking bench for mt_cmd_seq: cycle-accurate transaction model plus
// directed scenarios with hand-computed expectations.
module tb_mt_cmd_seq;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst, mtINIT, mtGO, mtWRL, mtBOT, mtERR, mtMOTDONE, mtXFRDONE, mtCLRATA;
  logic [4:0] mtFUN;
  logic mtMOTSTB, mtXFRSTB, mtDRVCLR, mtSETILF, mtSETNEF, mtSETRMR, mtSETOPI, mtDRY, mtATA;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int g;

  mt_cmd_seq #(.OPI_TIMEOUT(24'd16)) dut (
    .clk(clk), .rst(rst), .mtINIT(mtINIT), .mtGO(mtGO), .mtFUN(mtFUN),
    .mtWRL(mtWRL), .mtBOT(mtBOT), .mtERR(mtERR), .mtMOTDONE(mtMOTDONE),
    .mtXFRDONE(mtXFRDONE), .mtCLRATA(mtCLRATA), .mtMOTSTB(mtMOTSTB),
    .mtXFRSTB(mtXFRSTB), .mtDRVCLR(mtDRVCLR), .mtSETILF(mtSETILF),
    .mtSETNEF(mtSETNEF), .mtSETRMR(mtSETRMR), .mtSETOPI(mtSETOPI),
    .mtDRY(mtDRY), .mtATA(mtATA)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doGo(input logic [4:0] f, output int goCyc);
    mtFUN = f;
    mtGO  = 1'b1;
    goCyc = cyc;
    step(1);
    mtGO  = 1'b0;
  endtask

  // ---------------- transaction model ----------------
  bit started = 1'b0;
  bit pending, eMot, eXfr, eClr, eIlf, eNef, eRmr, eOpi, eAta, eDry;
  bit rmrC, setA, clrA;
  int kind, goAt, doneAt;
  logic [4:0] fn;

  function automatic bit isMot(input logic [4:0] f);
    return f inside {5'o01, 5'o03, 5'o12, 5'o13, 5'o14, 5'o15};
  endfunction
  function automatic bit isXfr(input logic [4:0] f);
    return f inside {5'o24, 5'o27, 5'o30, 5'o34, 5'o37};
  endfunction

  always @(posedge clk) begin
    {eMot, eXfr, eClr, eIlf, eNef, eRmr, eOpi} = 7'b0;
    rmrC = 1'b0; setA = 1'b0; clrA = mtCLRATA;
    if (rst || mtINIT) begin
      pending = 1'b0; kind = 0; doneAt = -1; eAta = 1'b0; eDry = 1'b1; started = 1'b1;
    end else begin
      if (!pending && mtGO) begin
        pending = 1'b1; fn = mtFUN; goAt = cyc; kind = 0; doneAt = -1;
      end else if (pending && mtGO) begin
        rmrC = 1'b1;
      end
      if (pending && cyc == goAt + 1) begin
        if (!(isMot(fn) || isXfr(fn) || fn inside {5'o00, 5'o04, 5'o10})) begin
          eIlf = 1'b1; setA = 1'b1; pending = 1'b0;
        end else if ((mtWRL && fn inside {5'o12, 5'o13, 5'o30}) ||
                     (mtBOT && fn inside {5'o15, 5'o27, 5'o37})) begin
          eNef = 1'b1; setA = 1'b1; pending = 1'b0;
        end else if (isMot(fn)) begin
          eMot = 1'b1; kind = 1;
        end else if (isXfr(fn)) begin
          eXfr = 1'b1; kind = 2;
        end else begin
          if (fn == 5'o04) begin eClr = 1'b1; clrA = 1'b1; end
          pending = 1'b0;
        end
      end else if (pending && kind != 0 && doneAt < 0) begin
        if ((kind == 1 && mtMOTDONE) || (kind == 2 && mtXFRDONE)) doneAt = cyc;
`ifdef MT_OPI_TIMEOUT_EN
        else if (cyc - (goAt + 2) == TMO - 1) begin
          eOpi = 1'b1; setA = 1'b1; pending = 1'b0;
        end
`endif
      end else if (pending && doneAt >= 0 && cyc == doneAt + 1) begin
        if (kind == 1 || mtERR) setA = 1'b1;
        pending = 1'b0;
      end
      eRmr = rmrC && !(eIlf || eNef || eOpi);
      eAta = setA ? 1'b1 : (clrA ? 1'b0 : eAta);
      eDry = !pending;
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started)
      chk("outputs{mot,xfr,clr,ilf,nef,rmr,opi,ata,dry}",
          {23'd0, mtMOTSTB, mtXFRSTB, mtDRVCLR, mtSETILF, mtSETNEF, mtSETRMR, mtSETOPI, mtATA, mtDRY},
          {23'd0, eMot, eXfr, eClr, eIlf, eNef, eRmr, eOpi, eAta, eDry});
  end

  initial begin
    rst = 1'b1; mtINIT = 1'b0; mtGO = 1'b1; mtFUN = 5'o03; mtWRL = 1'b0; mtBOT = 1'b0;
    mtERR = 1'b0; mtMOTDONE = 1'b0; mtXFRDONE = 1'b0; mtCLRATA = 1'b0;
    step(2);
    rst = 1'b0; mtGO = 1'b0;
    chk("reset_dry", mtDRY, 1); chk("reset_ata", mtATA, 0); chk("reset_motstb", mtMOTSTB, 0);
    step(1);
    chk("go_in_reset_ignored", mtDRY, 1);

    // illegal function
    doGo(5'o02, g); step(1);
    chk("ilf_pulse", mtSETILF, 1);
    step(1);
    chk("ilf_ata", mtATA, 1); chk("ilf_dry", mtDRY, 1); chk("ilf_width", mtSETILF, 0);
    mtCLRATA = 1'b1; step(1); mtCLRATA = 1'b0;
    chk("clrata", mtATA, 0);

    // write-locked WRF, then RDR at BOT
    mtWRL = 1'b1; doGo(5'o30, g); step(1);
    chk("nef_wrl", mtSETNEF, 1); chk("nef_no_xfr", mtXFRSTB, 0);
    step(1); chk("nef_ata", mtATA, 1);
    mtWRL = 1'b0; mtCLRATA = 1'b1; step(1); mtCLRATA = 1'b0;
    mtBOT = 1'b1; doGo(5'o37, g); step(1);
    chk("nef_bot", mtSETNEF, 1);
    mtBOT = 1'b0; mtCLRATA = 1'b1; step(1); mtCLRATA = 1'b0;

    // rewind, done 10 cycles after GO
    doGo(5'o03, g); step(1);
    chk("rew_motstb", mtMOTSTB, 1); chk("rew_dry_low", mtDRY, 0);
    step(8); chk("rew_busy", mtDRY, 0);
    mtMOTDONE = 1'b1; step(1); mtMOTDONE = 1'b0;
    chk("rew_done_dry", mtDRY, 0);
    step(1); chk("rew_idle_dry", mtDRY, 1); chk("rew_ata", mtATA, 1);
    mtCLRATA = 1'b1; step(1); mtCLRATA = 1'b0;
    chk("rew_clrata", mtATA, 0);

    // unload: done with the strobe, clear colliding with set
    doGo(5'o01, g); step(1);
    mtMOTDONE = 1'b1; chk("unl_motstb", mtMOTSTB, 1);
    step(1); mtMOTDONE = 1'b0; mtCLRATA = 1'b1;
    step(1); mtCLRATA = 1'b0;
    chk("set_wins_ata", mtATA, 1); chk("unl_dry", mtDRY, 1);

    // done during DECODE and in IDLE is ignored
    doGo(5'o14, g); mtMOTDONE = 1'b1; step(1); mtMOTDONE = 1'b0;
    step(3); chk("decode_done_ignored", mtDRY, 0);
    mtMOTDONE = 1'b1; step(1); mtMOTDONE = 1'b0; step(2);
    mtMOTDONE = 1'b1; step(1); mtMOTDONE = 1'b0; step(1);
    chk("idle_done_ignored", mtDRY, 1);

    // read forward with mtERR=0, GO mid-transfer
    mtCLRATA = 1'b1; step(1); mtCLRATA = 1'b0;
    doGo(5'o34, g); step(1);
    chk("rdf_xfrstb", mtXFRSTB, 1);
    step(2); mtGO = 1'b1; mtFUN = 5'o02; step(1); mtGO = 1'b0;
    chk("rmr_pulse", mtSETRMR, 1); chk("rmr_no_ilf", mtSETILF, 0);
    mtXFRDONE = 1'b1; step(1); mtXFRDONE = 1'b0; step(1);
    chk("rdf_ata_clean", mtATA, 0); chk("rdf_dry", mtDRY, 1);
    mtERR = 1'b1; doGo(5'o34, g); step(1);
    mtXFRDONE = 1'b1; step(1); mtXFRDONE = 1'b0; step(1);
    chk("rdf_ata_err", mtATA, 1);
    mtERR = 1'b0;

    // drive clear, NOP, PRESET, illegal with GO during DECODE
    doGo(5'o04, g); step(1);
    chk("drvclr_pulse", mtDRVCLR, 1); chk("drvclr_ata", mtATA, 0);
    doGo(5'o00, g); step(2); doGo(5'o10, g); step(2);
    chk("preset_ata", mtATA, 0);
    doGo(5'o07, g); mtGO = 1'b1; mtFUN = 5'o03; step(1); mtGO = 1'b0;
    chk("ilf_over_rmr", mtSETILF, 1); chk("rmr_suppressed", mtSETRMR, 0);
    step(1);

    // reset mid-transfer, mtINIT mid-motion
    doGo(5'o30, g); step(3);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("rst_mid_dry", mtDRY, 1); chk("rst_mid_ata", mtATA, 0);
    step(1); mtXFRDONE = 1'b1; step(1); mtXFRDONE = 1'b0; step(1);
    chk("late_xfrdone_dry", mtDRY, 1); chk("late_xfrdone_ata", mtATA, 0);
    doGo(5'o15, g); step(3);
    mtINIT = 1'b1; step(1); mtINIT = 1'b0;
    chk("init_mid_dry", mtDRY, 1);

`ifdef MT_OPI_TIMEOUT_EN
    doGo(5'o14, g); step(1);
    step(15); chk("opi_not_early", mtSETOPI, 0);
    step(1); chk("opi_pulse", mtSETOPI, 1);
    step(1); chk("opi_ata", mtATA, 1); chk("opi_dry", mtDRY, 1);
    doGo(5'o24, g); step(1); step(15);
    mtXFRDONE = 1'b1; step(1); mtXFRDONE = 1'b0;
    chk("opi_done_wins", mtSETOPI, 0);
    step(2);
`else
    doGo(5'o14, g); step(41);
    chk("no_timeout_busy", mtDRY, 0); chk("no_timeout_opi", mtSETOPI, 0);
    mtMOTDONE = 1'b1; step(1); mtMOTDONE = 1'b0; step(1);
    chk("no_timeout_done", mtDRY, 1);
`endif

    step(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
